// File: rtl/text_screen_pkg.sv
// Shared constants for the Wishbone text-screen controller:
// register offsets, control/status bit positions and FSM states.
package text_screen_pkg;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_CUR_X  = 3'd2;
    localparam logic [2:0] REG_CUR_Y  = 3'd3;
    localparam logic [2:0] REG_DATA   = 3'd4;
    localparam logic [2:0] REG_SCROLL = 3'd5;
    localparam logic [2:0] REG_FILL   = 3'd6;
    localparam logic [2:0] REG_RSVD   = 3'd7;

    localparam int CTRL_AUTO_INC = 0;
    localparam int CTRL_WRAP     = 1;
    localparam int CTRL_CLEAR    = 2;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_WRAPPED = 1;

    localparam logic [7:0] FILL_RST = 8'h20;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD_WAIT,
        S_ACK,
        S_CLEAR
    } state_t;

endpackage

// File: rtl/text_screen_ram.sv
// Character buffer: port A read/write for the bus and clear engine,
// port B read-only for scan-out. Both reads are registered.
module text_screen_ram #(
    parameter int DEPTH  = 4800,
    parameter int A_W    = 13,
    parameter int CHAR_W = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_we,
    input  logic [A_W-1:0]    a_addr,
    input  logic [CHAR_W-1:0] a_wdata,
    output logic [CHAR_W-1:0] a_rdata,
    input  logic [A_W-1:0]    b_addr,
    output logic [CHAR_W-1:0] b_rdata
);

    logic [CHAR_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (a_we) begin
            mem[a_addr] <= a_wdata;
        end
        a_rdata <= mem[a_addr];
    end

    // Read-before-write: a same-address write shows old data here.
    always_ff @(posedge clk) begin
        if (reset) begin
            b_rdata <= '0;
        end else begin
            b_rdata <= mem[b_addr];
        end
    end

endmodule

// File: rtl/text_screen_wb.sv
// Wishbone text-screen controller: cursor, wrap, fill/clear engine,
// hardware scroll and a registered scan-out read port.
module text_screen_wb
    import text_screen_pkg::*;
#(
    parameter int COLS   = 80,
    parameter int ROWS   = 60,
    parameter int CHAR_W = 7,
    parameter int X_W    = $clog2(COLS),
    parameter int Y_W    = $clog2(ROWS),
    parameter int A_W    = $clog2(COLS * ROWS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_stb_i,
    input  logic              wb_cyc_i,
    input  logic              wb_we_i,
    input  logic [31:0]       wb_adr_i,
    input  logic [3:0]        wb_sel_i,
    input  logic [31:0]       wb_dat_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o,
    input  logic [X_W-1:0]    disp_x,
    input  logic [Y_W-1:0]    disp_y,
    output logic [CHAR_W-1:0] disp_char,
    output logic              busy
);

    localparam int YS_W  = Y_W + 1;
    localparam int DEPTH = COLS * ROWS;
    localparam logic [X_W-1:0]  X_MAX  = X_W'(COLS - 1);
    localparam logic [Y_W-1:0]  Y_MAX  = Y_W'(ROWS - 1);
    localparam logic [YS_W-1:0] ROWS_S = YS_W'(ROWS);
    localparam logic [A_W-1:0]  A_MAX  = A_W'(DEPTH - 1);

    state_t state, state_nx;

    logic              auto_inc, wrap, wrapped;
    logic [X_W-1:0]    cur_x;
    logic [Y_W-1:0]    cur_y, scroll, phys_y;
    logic [YS_W-1:0]   row_sum;
    logic [CHAR_W-1:0] fill;
    logic [A_W-1:0]    clr_addr, cur_addr, disp_addr;
    logic              pend_data, pend_clear;
    logic              req, acc, is_data;
    logic [2:0]        sel_reg;
    logic [31:0]       rd_val;
    logic              ram_we;
    logic [A_W-1:0]    ram_addr;
    logic [CHAR_W-1:0] ram_wdata, ram_rdata;
    logic              unused_bits;

    // y*COLS + x as a sum of shifted rows, one term per set bit of COLS.
    function automatic logic [A_W-1:0] lin(
        input logic [X_W-1:0] x,
        input logic [Y_W-1:0] y
    );
        logic [A_W-1:0] sum;
        sum = A_W'(x);
        for (int k = 0; k < 8; k++) begin
            if (((COLS >> k) & 1) != 0) begin
                sum = sum + (A_W'(y) << k);
            end
        end
        return sum;
    endfunction

    function automatic logic [X_W-1:0] clamp_x(input logic [31:0] v);
        return (v >= 32'(COLS)) ? X_MAX : v[X_W-1:0];
    endfunction

    function automatic logic [Y_W-1:0] clamp_y(input logic [31:0] v);
        return (v >= 32'(ROWS)) ? Y_MAX : v[Y_W-1:0];
    endfunction

    assign unused_bits = ^{wb_sel_i, wb_adr_i[31:5], wb_adr_i[1:0]};

    assign req      = wb_stb_i & wb_cyc_i;
    assign acc      = req && (state == S_IDLE);
    assign sel_reg  = wb_adr_i[4:2];
    assign is_data  = (sel_reg == REG_DATA);
    assign cur_addr = lin(cur_x, cur_y);

    always_comb begin
        row_sum = {1'b0, disp_y} + {1'b0, scroll};
        if (row_sum >= ROWS_S) begin
            phys_y = Y_W'(row_sum - ROWS_S);
        end else begin
            phys_y = row_sum[Y_W-1:0];
        end
        disp_addr = lin(disp_x, phys_y);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (acc) begin
                    state_nx = (is_data && !wb_we_i) ? S_RD_WAIT : S_ACK;
                end
            end
            S_RD_WAIT: state_nx = S_ACK;
            S_ACK:     state_nx = pend_clear ? S_CLEAR : S_IDLE;
            S_CLEAR: begin
                if (clr_addr == A_MAX) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        wb_ack_o  = 1'b0;
        busy      = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = cur_addr;
        ram_wdata = wb_dat_i[CHAR_W-1:0];
        unique case (state)
            S_IDLE:  ram_we = acc && is_data && wb_we_i;
            S_ACK:   wb_ack_o = req;
            S_CLEAR: begin
                busy      = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = clr_addr;
                ram_wdata = fill;
            end
            default: ;
        endcase
    end

    always_comb begin
        rd_val = '0;
        case (sel_reg)
            REG_CTRL:   rd_val = 32'({wrap, auto_inc});
            REG_STATUS: rd_val = 32'({wrapped, busy});
            REG_CUR_X:  rd_val = 32'(cur_x);
            REG_CUR_Y:  rd_val = 32'(cur_y);
            REG_SCROLL: rd_val = 32'(scroll);
            REG_FILL:   rd_val = 32'(fill);
            REG_DATA,
            REG_RSVD:   rd_val = '0;
            default:    rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_dat_o   <= '0;
            auto_inc   <= 1'b0;
            wrap       <= 1'b0;
            wrapped    <= 1'b0;
            cur_x      <= '0;
            cur_y      <= '0;
            scroll     <= '0;
            fill       <= CHAR_W'(FILL_RST);
            clr_addr   <= '0;
            pend_data  <= 1'b0;
            pend_clear <= 1'b0;
        end else begin
            if (acc) begin
                pend_data  <= is_data;
                pend_clear <= wb_we_i && (sel_reg == REG_CTRL)
                              && wb_dat_i[CTRL_CLEAR];
                wb_dat_o   <= wb_we_i ? '0 : rd_val;
                if (wb_we_i) begin
                    case (sel_reg)
                        REG_CTRL: begin
                            auto_inc <= wb_dat_i[CTRL_AUTO_INC];
                            wrap     <= wb_dat_i[CTRL_WRAP];
                        end
                        REG_STATUS: begin
                            if (wb_dat_i[STAT_WRAPPED]) begin
                                wrapped <= 1'b0;
                            end
                        end
                        REG_CUR_X:  cur_x  <= clamp_x(wb_dat_i);
                        REG_CUR_Y:  cur_y  <= clamp_y(wb_dat_i);
                        REG_SCROLL: scroll <= clamp_y(wb_dat_i);
                        REG_FILL:   fill   <= wb_dat_i[CHAR_W-1:0];
                        default: ;
                    endcase
                end
            end
            if (state == S_RD_WAIT) begin
                wb_dat_o <= 32'(ram_rdata);
            end
            if (state == S_ACK) begin
                clr_addr <= '0;
                if (pend_data && auto_inc) begin
                    if (cur_x != X_MAX) begin
                        cur_x <= cur_x + 1'b1;
                    end else if (cur_y != Y_MAX) begin
                        cur_x <= '0;
                        cur_y <= cur_y + 1'b1;
                    end else if (wrap) begin
                        cur_x   <= '0;
                        cur_y   <= '0;
                        wrapped <= 1'b1;
                    end
                end
            end
            if (state == S_CLEAR) begin
                clr_addr <= clr_addr + 1'b1;
                if (clr_addr == A_MAX) begin
                    cur_x <= '0;
                    cur_y <= '0;
                end
            end
        end
    end

    text_screen_ram #(
        .DEPTH  (DEPTH),
        .A_W    (A_W),
        .CHAR_W (CHAR_W)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .a_we    (ram_we),
        .a_addr  (ram_addr),
        .a_wdata (ram_wdata),
        .a_rdata (ram_rdata),
        .b_addr  (disp_addr),
        .b_rdata (disp_char)
    );

endmodule

// File: tb/tb_text_screen_wb.sv
// Bench for text_screen_wb: register table, scripted corner cases
// and random traffic against a linear-position reference model.
module tb_text_screen_wb;

    localparam int COLS   = 80;
    localparam int ROWS   = 60;
    localparam int CHAR_W = 7;
    localparam int X_W    = $clog2(COLS);
    localparam int Y_W    = $clog2(ROWS);
    localparam int DEPTH  = COLS * ROWS;
    localparam int CMASK  = (1 << CHAR_W) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [31:0]       adr = '0, dat_w = '0;
    logic [3:0]        sel = 4'hF;
    logic [31:0]       dat_r;
    logic              ack, busy;
    logic [X_W-1:0]    disp_x = '0;
    logic [Y_W-1:0]    disp_y = '0;
    logic [CHAR_W-1:0] disp_char;

    int pass_cnt = 0;
    int total_cnt = 0;
    int busy_cnt = 0;

    // Reference model state
    int m_auto, m_wrap, m_wrapped, m_cx, m_cy, m_scroll, m_fill;
    int m_mem [DEPTH];

    typedef struct {
        bit          wr;
        int          off;
        logic [31:0] dat;
        longint      exp;
        int          lat;
    } vec_t;

    vec_t tbl [$];

    text_screen_wb dut (
        .clk       (clk),
        .reset     (reset),
        .wb_stb_i  (stb),
        .wb_cyc_i  (cyc),
        .wb_we_i   (we),
        .wb_adr_i  (adr),
        .wb_sel_i  (sel),
        .wb_dat_i  (dat_w),
        .wb_dat_o  (dat_r),
        .wb_ack_o  (ack),
        .disp_x    (disp_x),
        .disp_y    (disp_y),
        .disp_char (disp_char),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (busy) busy_cnt++;
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        total_cnt++;
        if (act == exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic m_reset_regs();
        m_auto = 0; m_wrap = 0; m_wrapped = 0;
        m_cx = 0; m_cy = 0; m_scroll = 0; m_fill = 'h20;
    endtask

    // Cursor as a single linear position 0..DEPTH-1.
    task automatic m_adv();
        int pos;
        if (m_auto == 0) return;
        pos = m_cy * COLS + m_cx;
        if (pos < DEPTH - 1) begin
            pos++;
        end else if (m_wrap != 0) begin
            pos = 0;
            m_wrapped = 1;
        end
        m_cx = pos % COLS;
        m_cy = pos / COLS;
    endtask

    function automatic int clampv(input longint v, input int lim);
        return (v >= lim) ? lim - 1 : int'(v);
    endfunction

    task automatic m_write(input int off, input logic [31:0] d);
        longint v;
        v = longint'(d);
        case (off)
            'h00: begin
                m_auto = int'(d[0]);
                m_wrap = int'(d[1]);
                if (d[2]) begin
                    foreach (m_mem[i]) m_mem[i] = m_fill;
                    m_cx = 0;
                    m_cy = 0;
                end
            end
            'h04: if (d[1]) m_wrapped = 0;
            'h08: m_cx = clampv(v, COLS);
            'h0C: m_cy = clampv(v, ROWS);
            'h10: begin
                m_mem[m_cy * COLS + m_cx] = int'(v & CMASK);
                m_adv();
            end
            'h14: m_scroll = clampv(v, ROWS);
            'h18: m_fill = int'(v & CMASK);
            default: ;
        endcase
    endtask

    task automatic m_read(input int off, output longint exp);
        case (off)
            'h00: exp = m_wrap * 2 + m_auto;
            'h04: exp = m_wrapped * 2;
            'h08: exp = m_cx;
            'h0C: exp = m_cy;
            'h10: begin
                exp = m_mem[m_cy * COLS + m_cx];
                m_adv();
            end
            'h14: exp = m_scroll;
            'h18: exp = m_fill;
            default: exp = 0;
        endcase
    endtask

    // Called #1 after an edge; returns #1 after the edge following the ack.
    task automatic wb_acc(input bit w, input int off, input logic [31:0] d,
                          input int budget, output logic [31:0] rd,
                          output int lat);
        stb = 1'b1; cyc = 1'b1; we = w; adr = 32'(off); dat_w = d;
        lat = -1;
        rd = '0;
        for (int n = 1; n <= budget; n++) begin
            @(posedge clk); #1;
            if (ack) begin
                lat = n;
                rd = dat_r;
                break;
            end
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_wr(input int off, input logic [31:0] d);
        logic [31:0] rd;
        int lat;
        wb_acc(1'b1, off, d, 10, rd, lat);
        chk($sformatf("wr%0h_lat", off), longint'(lat), 1);
        m_write(off, d);
    endtask

    task automatic do_rd(input string nm, input int off, output logic [31:0] v);
        int lat;
        longint exp;
        wb_acc(1'b0, off, '0, 10, v, lat);
        chk({nm, "_lat"}, longint'(lat), (off == 'h10) ? 2 : 1);
        m_read(off, exp);
        if (exp >= 0) chk(nm, longint'(v), exp);
    endtask

    task automatic disp_chk(input string nm, input int x, input int y,
                            output logic [CHAR_W-1:0] v);
        int row;
        disp_x = X_W'(x);
        disp_y = Y_W'(y);
        @(posedge clk); #1;
        v = disp_char;
        row = (y + m_scroll) % ROWS;
        if (m_mem[row * COLS + x] >= 0)
            chk(nm, longint'(v), longint'(m_mem[row * COLS + x]));
    endtask

    task automatic add(input bit w, input int off, input logic [31:0] d,
                       input longint exp);
        vec_t e;
        e.wr = w; e.off = off; e.dat = d; e.exp = exp; e.lat = 1;
        tbl.push_back(e);
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (busy && n < 6000) begin
            @(posedge clk); #1;
            n++;
        end
        chk(nm, longint'(busy), 0);
    endtask

    initial begin
        logic [31:0]       v;
        logic [CHAR_W-1:0] c;
        int                lat, bc, op;

        foreach (m_mem[i]) m_mem[i] = -1;
        m_reset_regs();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", longint'(ack), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_dat", longint'(dat_r), 0);
        chk("rst_disp", longint'(disp_char), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Register table: reset values, clamping, reserved slot
        add(0, 'h00, 0, 0);
        add(0, 'h04, 0, 0);
        add(0, 'h08, 0, 0);
        add(0, 'h0C, 0, 0);
        add(0, 'h14, 0, 0);
        add(0, 'h18, 0, 'h20);
        add(0, 'h1C, 0, 0);
        add(1, 'h08, 200, 0);
        add(0, 'h08, 0, 79);
        add(1, 'h0C, 99, 0);
        add(0, 'h0C, 0, 59);
        add(1, 'h0C, 32'hFFFF_FFFF, 0);
        add(0, 'h0C, 0, 59);
        add(1, 'h14, 70, 0);
        add(0, 'h14, 0, 59);
        add(1, 'h14, 3, 0);
        add(0, 'h14, 0, 3);
        add(1, 'h18, 'h1FF, 0);
        add(0, 'h18, 0, 'h7F);
        add(1, 'h1C, 'h55, 0);
        add(0, 'h1C, 0, 0);
        add(1, 'h00, 3, 0);
        add(0, 'h00, 0, 3);
        add(1, 'h00, 0, 0);
        add(0, 'h00, 0, 0);
        add(1, 'h08, 5, 0);
        add(0, 'h08, 0, 5);
        add(1, 'h14, 0, 0);
        add(1, 'h18, 'h20, 0);
        add(0, 'h18, 0, 'h20);
        foreach (tbl[i]) begin
            wb_acc(tbl[i].wr, tbl[i].off, tbl[i].dat, 10, v, lat);
            chk($sformatf("tbl%0d_lat", i), longint'(lat), longint'(tbl[i].lat));
            if (tbl[i].wr) m_write(tbl[i].off, tbl[i].dat);
            else chk($sformatf("tbl%0d_rd", i), longint'(v), tbl[i].exp);
        end

        // Auto-increment across a row boundary
        do_wr('h00, 1);
        do_wr('h08, 78);
        do_wr('h0C, 0);
        do_wr('h10, 'h41);
        do_wr('h10, 'h42);
        do_wr('h10, 'h43);
        do_rd("t2_cx", 'h08, v);
        chk("t2_cx_k", longint'(v), 1);
        do_rd("t2_cy", 'h0C, v);
        chk("t2_cy_k", longint'(v), 1);
        disp_chk("t2_d79", 79, 0, c);
        chk("t2_d79_k", longint'(c), 'h42);
        disp_chk("t2_d78", 78, 0, c);
        disp_chk("t2_d80", 0, 1, c);
        chk("t2_d80_k", longint'(c), 'h43);
        do_wr('h08, 78);
        do_wr('h0C, 0);
        do_rd("t2_rd", 'h10, v);
        chk("t2_rd_k", longint'(v), 'h41);
        do_rd("t2_cx2", 'h08, v);

        // Last cell: wrap vs saturate
        do_wr('h00, 3);
        do_wr('h08, 79);
        do_wr('h0C, 59);
        do_wr('h10, 'h5A);
        do_rd("t3_cx", 'h08, v);
        chk("t3_cx_k", longint'(v), 0);
        do_rd("t3_cy", 'h0C, v);
        do_rd("t3_st", 'h04, v);
        chk("t3_st_k", longint'(v), 2);
        do_wr('h04, 2);
        do_rd("t3_st2", 'h04, v);
        do_wr('h00, 1);
        do_wr('h08, 79);
        do_wr('h0C, 59);
        do_wr('h10, 'h5B);
        do_rd("t3_sx", 'h08, v);
        chk("t3_sx_k", longint'(v), 79);
        do_rd("t3_sy", 'h0C, v);
        chk("t3_sy_k", longint'(v), 59);
        do_rd("t3_st3", 'h04, v);

        // Clear with a DATA write held until the engine finishes
        do_wr('h18, 'h2E);
        busy_cnt = 0;
        do_wr('h00, 4);
        repeat (10) @(posedge clk);
        #1;
        chk("t4_busy", longint'(busy), 1);
        wb_acc(1'b1, 'h10, 'h55, 6000, v, lat);
        bc = busy_cnt;
        chk("t4_held_ack", longint'(lat > 1), 1);
        chk("t4_busy_len", longint'(bc), DEPTH);
        chk("t4_busy_end", longint'(busy), 0);
        m_write('h10, 'h55);
        bc = 0;
        for (int y = 0; y < ROWS; y++) begin
            for (int x = 0; x < COLS; x++) begin
                disp_x = X_W'(x);
                disp_y = Y_W'(y);
                @(posedge clk); #1;
                if (int'(disp_char) != m_mem[y * COLS + x]) bc++;
            end
        end
        chk("t4_scan_bad", longint'(bc), 0);
        do_rd("t4_rd00", 'h10, v);
        chk("t4_rd00_k", longint'(v), 'h55);

        // Hardware scroll and its clamp
        do_wr('h00, 0);
        do_wr('h08, 0);
        do_wr('h0C, 2);
        do_wr('h10, 'h51);
        do_wr('h14, 2);
        disp_chk("t5_q", 0, 0, c);
        chk("t5_q_k", longint'(c), 'h51);
        do_wr('h14, 70);
        do_rd("t5_scr", 'h14, v);
        chk("t5_scr_k", longint'(v), 59);
        disp_chk("t5_wrap", 0, 1, c);
        chk("t5_wrap_k", longint'(c), 'h55);

        // Reset in the middle of a clear
        do_wr('h18, 'h23);
        do_wr('h00, 4);
        repeat (100) @(posedge clk);
        #1;
        chk("t6_busy", longint'(busy), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("t6_rst_busy", longint'(busy), 0);
        chk("t6_rst_ack", longint'(ack), 0);
        reset = 1'b0;
        m_reset_regs();
        foreach (m_mem[i]) m_mem[i] = -1;
        m_mem[0] = 'h23;
        do_rd("t6_ctrl", 'h00, v);
        do_rd("t6_fill", 'h18, v);
        chk("t6_fill_k", longint'(v), 'h20);
        do_rd("t6_cx", 'h08, v);
        do_rd("t6_scr", 'h14, v);
        do_rd("t6_st", 'h04, v);
        do_rd("t6_data", 'h10, v);

        // Resynchronise buffer contents before random traffic
        do_wr('h00, 4);
        @(posedge clk); #1;
        wait_idle("t6_clear_done");

        for (int it = 0; it < 400; it++) begin
            op = $urandom_range(0, 10);
            case (op)
                0: do_wr('h08, $urandom_range(COLS - 3, COLS + 20));
                1: do_wr('h0C, $urandom_range(ROWS - 3, ROWS + 10));
                2: do_wr('h00, $urandom_range(0, 3));
                3, 4: do_wr('h10, $urandom());
                5: do_rd("r_data", 'h10, v);
                6: do_rd("r_reg", 4 * $urandom_range(0, 7), v);
                7: do_wr('h04, $urandom_range(0, 3));
                8: do_wr('h14, $urandom_range(0, ROWS + 10));
                9: do_wr('h08, $urandom());
                default: disp_chk("r_disp", $urandom_range(0, COLS - 1),
                                  $urandom_range(0, ROWS - 1), c);
            endcase
        end
        do_rd("r_cx_end", 'h08, v);
        do_rd("r_cy_end", 'h0C, v);
        do_rd("r_st_end", 'h04, v);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
